// File: rtl/riscv_multi_cycle_core.sv
// riscv_multi_cycle_core: multi-cycle RV32I-subset core with one shared req/ready memory port
//   clk, rst          clock and synchronous active-high reset
//   mem_req/mem_we    transfer request and direction (1 = store)
//   mem_addr          word address, low two bits always 0
//   mem_wdata         store data (rs2)
//   mem_ready         transfer completes in any cycle with mem_req && mem_ready
//   mem_rdata         read data, sampled in the completing cycle
//   retire            one-cycle pulse in each instruction's final state
//   pc_dbg            current PC
//   trap              sticky illegal-instruction flag
// Build option RISCV_ILLEGAL_TRAP_EN: unknown instructions set trap and halt until rst;
// without it they retire as NOPs and trap is tied 0.
module riscv_multi_cycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              retire,
    output logic [31:0]       pc_dbg,
    output logic              trap
);
    localparam int RW = $clog2(NUM_REGS);
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB
`ifdef RISCV_ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t state, next;
    logic [31:0] pc, ir, a, b, imm, alu_out, mdr;
    logic [31:0] regs [NUM_REGS];

    logic [6:0] opc, f7;
    logic [2:0] f3, alu_f3;
    logic [RW-1:0] rs1, rs2, rd;
    logic [31:0] imm_d, op2, alu, pc4, tgt, wb_data;
    logic legal, f3_ok, sub, taken;

    assign opc = ir[6:0];
    assign f3  = ir[14:12];
    assign f7  = ir[31:25];
    assign rs1 = ir[15 +: RW];
    assign rs2 = ir[20 +: RW];
    assign rd  = ir[7 +: RW];

    assign f3_ok = f3 inside {3'b000, 3'b010, 3'b100, 3'b110, 3'b111};
    assign legal = opc == OP_LUI || opc == OP_JAL
                || (opc == OP_R && ((f7 == 7'h00 && f3_ok) || (f7 == 7'h20 && f3 == 3'b000)))
                || (opc == OP_I && f3_ok)
                || ((opc == OP_LW || opc == OP_SW) && f3 == 3'b010)
                || (opc == OP_BR && f3[2:1] == 2'b00);

    assign imm_d = opc == OP_SW  ? {{20{ir[31]}}, ir[31:25], ir[11:7]}
                 : opc == OP_BR  ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}
                 : opc == OP_JAL ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}
                 : opc == OP_LUI ? {ir[31:12], 12'b0}
                 : {{20{ir[31]}}, ir[31:20]};

    // Loads/stores reuse the adder, so their funct3 must not select SLT
    assign alu_f3 = (opc == OP_R || opc == OP_I) ? f3 : 3'b000;
    assign op2    = opc == OP_R ? b : imm;
    assign sub    = opc == OP_R && f7[5];
    assign alu    = alu_f3 == 3'b111 ? a & op2
                  : alu_f3 == 3'b110 ? a | op2
                  : alu_f3 == 3'b100 ? a ^ op2
                  : alu_f3 == 3'b010 ? {31'b0, $signed(a) < $signed(op2)}
                  : sub ? a - op2 : a + op2;

    assign taken   = (a == b) ^ f3[0];
    assign pc4     = pc + 32'd4;
    assign tgt     = {pc[31:2] + imm[31:2], 2'b00};
    assign wb_data = opc == OP_LUI ? imm : opc == OP_JAL ? pc4 : opc == OP_LW ? mdr : alu_out;

    assign mem_wdata = b;
    assign pc_dbg    = pc;

    always_comb begin
        next     = state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        retire   = 1'b0;
        mem_addr = {pc[ADDR_W-1:2], 2'b00};
        case (state)
            FETCH: begin
                mem_req = 1'b1;
                next    = mem_ready ? DECODE : FETCH;
            end
            DECODE: next = EXEC;
            EXEC: begin
                if (!legal) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
                    next = HALT;
`else
                    retire = 1'b1;
                    next   = FETCH;
`endif
                end else if (opc == OP_BR) begin
                    retire = 1'b1;
                    next   = FETCH;
                end else begin
                    next = (opc == OP_LW || opc == OP_SW) ? MEM : WB;
                end
            end
            MEM: begin
                mem_req  = 1'b1;
                mem_we   = opc == OP_SW;
                mem_addr = {alu_out[ADDR_W-1:2], 2'b00};
                retire   = mem_we && mem_ready;
                next     = mem_ready ? (mem_we ? FETCH : WB) : MEM;
            end
            WB: begin
                retire = 1'b1;
                next   = FETCH;
            end
            default: next = state;
        endcase
        // Reset silences the bus immediately so an in-flight store never completes
        if (rst) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
            retire  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            pc    <= RESET_PC;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            state <= next;
            case (state)
                FETCH: if (mem_ready) ir <= mem_rdata;
                DECODE: begin
                    a   <= regs[rs1];
                    b   <= regs[rs2];
                    imm <= imm_d;
                end
                EXEC: begin
                    alu_out <= alu;
                    if (opc == OP_BR && legal) pc <= taken ? tgt : pc4;
`ifndef RISCV_ILLEGAL_TRAP_EN
                    else if (!legal) pc <= pc4;
`endif
                end
                MEM: if (mem_ready) begin
                    if (opc == OP_SW) pc <= pc4;
                    else mdr <= mem_rdata;
                end
                WB: begin
                    if (rd != '0) regs[rd] <= wb_data;
                    pc <= opc == OP_JAL ? tgt : pc4;
                end
                default: ;
            endcase
        end
    end

`ifdef RISCV_ILLEGAL_TRAP_EN
    always_ff @(posedge clk) trap <= rst ? 1'b0 : trap | (state == EXEC && !legal);
`else
    assign trap = 1'b0;
`endif
endmodule

// File: tb/tb_riscv_multi_cycle_core.sv
// tb_riscv_multi_cycle_core: self-checking bench with store scoreboard and wait-state memory model
module tb_riscv_multi_cycle_core;
    logic clk = 1'b0, rst = 1'b1;
    logic mem_req, mem_we, mem_ready, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

    riscv_multi_cycle_core #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .retire(retire), .pc_dbg(pc_dbg), .trap(trap)
    );

    always #5 clk = ~clk;

    logic [31:0] prog [512];
    logic [31:0] dmem [512];
    logic        dv [512];
    int wait_n = 0, wcnt = 0, cyc = 0, n_st = 0, c0 = 0, s0 = 0;
    int n_pass = 0, n_chk = 0;
    logic [31:0] sb_a [$], sb_d [$], rpc [$];
    int rcyc [$];
    logic [31:0] ld, ea, ed;
    logic hold = 1'b0;
    logic [31:0] h_addr, h_wd;
    logic h_we;
    logic [8:0] idx;

    assign idx       = mem_addr[10:2];
    assign mem_ready = wcnt >= wait_n;
    assign mem_rdata = dv[idx] ? dmem[idx] : prog[idx];

    always @(posedge clk) wcnt <= (rst || (mem_req && mem_ready)) ? 0 : mem_req ? wcnt + 1 : wcnt;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int i = 0; i < 512; i++) dv[i] = 1'b0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("req held during wait", 32'(mem_req), 32'd1);
                check("addr stable during wait", mem_addr, h_addr);
                check("we stable during wait", 32'(mem_we), 32'(h_we));
                check("wdata stable during wait", mem_wdata, h_wd);
            end
            hold   = mem_req && !mem_ready;
            h_addr = mem_addr;
            h_we   = mem_we;
            h_wd   = mem_wdata;
            if (mem_req && mem_ready && mem_we) begin
                n_st++;
                dmem[idx] = mem_wdata;
                dv[idx]   = 1'b1;
                if (sb_a.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected store: addr %h data %h", mem_addr, mem_wdata);
                end else begin
                    ea = sb_a.pop_front();
                    ed = sb_d.pop_front();
                    check("store addr", mem_addr, ea);
                    check("store data", mem_wdata, ed);
                end
            end
            if (retire) begin
                rpc.push_back(pc_dbg);
                rcyc.push_back(cyc);
            end
        end
    end

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] i_t(input logic [11:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {im, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] sw_t(input logic [4:0] rs2, input logic [11:0] im);
        return {im[11:5], rs2, 5'd0, 3'b010, im[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] lw_t(input logic [4:0] rd, input logic [11:0] im);
        return {im, 5'd0, 3'b010, rd, 7'h03};
    endfunction
    function automatic logic [31:0] b_t(input logic [12:0] im, input logic [4:0] rs2, rs1, input logic [2:0] f3);
        return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'h63};
    endfunction
    function automatic logic [31:0] j_t(input logic [20:0] im, input logic [4:0] rd);
        return {im[20], im[10:1], im[11], im[19:12], rd, 7'h6f};
    endfunction
    function automatic logic [31:0] addi(input logic [4:0] rd, rs1, input logic [11:0] im);
        return i_t(im, rs1, 3'b000, rd, 7'h13);
    endfunction

    task automatic put(input logic [31:0] w);
        prog[ld[10:2]] = w;
        ld += 32'd4;
    endtask
    task automatic exp_st(input logic [31:0] a, d);
        sb_a.push_back(a);
        sb_d.push_back(d);
    endtask
    task automatic rst_on();
        @(posedge clk);
        #1 rst = 1'b1;
        for (int i = 0; i < 512; i++) prog[i] = 32'h0;
        sb_a.delete(); sb_d.delete(); rpc.delete(); rcyc.delete();
        ld = 32'h100;
    endtask
    task automatic rst_off();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        c0 = cyc;
    endtask
    task automatic wait_ret(input int n);
        int k = 0;
        while (rpc.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rpc.size() < n) begin
            n_chk++;
            $display("FAIL retire timeout: got %0d retires, need %0d", rpc.size(), n);
        end
    endtask

    typedef struct {
        logic        imm;
        logic        sub;
        logic [2:0]  f3;
        logic [31:0] a, b, exp;
    } vec_t;
    vec_t vt [16];
    logic [31:0] bpc [7];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b0, 1'b0, 3'b000, 32'd5,         32'hFFFF_FFFD, 32'd2};
        vt[1]  = '{1'b0, 1'b1, 3'b000, 32'd5,         32'd7,         32'hFFFF_FFFE};
        vt[2]  = '{1'b0, 1'b0, 3'b111, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200};
        vt[3]  = '{1'b0, 1'b0, 3'b110, 32'hF000_000F, 32'h0000_FF00, 32'hF000_FF0F};
        vt[4]  = '{1'b0, 1'b0, 3'b100, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F};
        vt[5]  = '{1'b0, 1'b0, 3'b010, 32'hFFFF_FFFD, 32'd5,         32'd1};
        vt[6]  = '{1'b0, 1'b0, 3'b010, 32'd5,         32'hFFFF_FFFD, 32'd0};
        vt[7]  = '{1'b0, 1'b0, 3'b010, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1};
        vt[8]  = '{1'b0, 1'b0, 3'b000, 32'hFFFF_FFFF, 32'd1,         32'd0};
        vt[9]  = '{1'b1, 1'b0, 3'b000, 32'd10,        32'h0000_0FFF, 32'd9};
        vt[10] = '{1'b1, 1'b0, 3'b111, 32'hFFFF_00FF, 32'h0000_080F, 32'hFFFF_000F};
        vt[11] = '{1'b1, 1'b0, 3'b110, 32'h0000_0100, 32'h0000_00FF, 32'h0000_01FF};
        vt[12] = '{1'b1, 1'b0, 3'b100, 32'h5555_5555, 32'h0000_0FFF, 32'hAAAA_AAAA};
        vt[13] = '{1'b1, 1'b0, 3'b010, 32'hFFFF_FFFE, 32'h0000_0FFF, 32'd1};
        vt[14] = '{1'b1, 1'b0, 3'b010, 32'd0,         32'd0,         32'd0};
        vt[15] = '{1'b1, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000};
        bpc = '{32'h100, 32'h104, 32'h108, 32'h118, 32'h110, 32'h114, 32'h120};

        // Reset, ALU latency, then wait-state store/load
        for (int i = 0; i < 512; i++) prog[i] = 32'h0;
        ld = 32'h100;
        put(addi(5'd1, 5'd0, 12'd5));
        put(addi(5'd2, 5'd0, 12'hFFD));
        put(r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));
        put(r_t(7'h00, 5'd1, 5'd2, 3'b010, 5'd4));
        put(sw_t(5'd3, 12'd8));
        put(sw_t(5'd4, 12'd12));
        put(lw_t(5'd5, 12'd8));
        put(sw_t(5'd5, 12'd16));
        exp_st(32'd8, 32'd2);
        exp_st(32'd12, 32'd1);
        exp_st(32'd16, 32'd2);
        @(posedge clk);
        @(negedge clk);
        check("reset outputs", 32'({mem_req, mem_we, retire, trap}), 32'd0);
        check("reset pc", pc_dbg, 32'h100);
        @(posedge clk);
        #1 rst = 1'b0;
        c0 = cyc;
        @(negedge clk);
        check("first fetch req", 32'({mem_req, mem_we}), 32'b10);
        check("first fetch addr", mem_addr, 32'h100);
        wait_ret(4);
        check("4 alu retires cycles", 32'(rcyc[3] - c0), 32'd16);
        wait_n = 3;
        wait_ret(8);
        check("sw with waits cycles", 32'(rcyc[5] - rcyc[4]), 32'd10);
        check("lw with waits cycles", 32'(rcyc[6] - rcyc[5]), 32'd11);
        check("scoreboard drained", 32'(sb_a.size()), 32'd0);

        // Table-driven ALU vectors: load operands, operate, store result
        rst_on();
        for (int i = 0; i < 16; i++) begin
            prog[(32'h400 + 8 * i) >> 2] = vt[i].a;
            prog[(32'h404 + 8 * i) >> 2] = vt[i].b;
            put(lw_t(5'd1, 12'(32'h400 + 8 * i)));
            put(lw_t(5'd2, 12'(32'h404 + 8 * i)));
            put(vt[i].imm ? i_t(vt[i].b[11:0], 5'd1, vt[i].f3, 5'd3, 7'h13)
                          : r_t(vt[i].sub ? 7'h20 : 7'h00, 5'd2, 5'd1, vt[i].f3, 5'd3));
            put(sw_t(5'd3, 12'(32'h600 + 4 * i)));
            exp_st(32'h600 + 32'(4 * i), vt[i].exp);
        end
        wait_n = 1;
        rst_off();
        wait_ret(64);
        check("alu scoreboard drained", 32'(sb_a.size()), 32'd0);

        // Branches and jumps
        rst_on();
        wait_n = 0;
        put(addi(5'd1, 5'd0, 12'd1));
        put(b_t(13'd100, 5'd1, 5'd1, 3'b001));
        put(j_t(21'd16, 5'd7));
        put(addi(5'd8, 5'd0, 12'd1));
        put(sw_t(5'd7, 12'h20));
        put(j_t(21'd12, 5'd0));
        put(b_t(13'h1FF8, 5'd1, 5'd1, 3'b000));
        put(32'h0);
        put(sw_t(5'd8, 12'h24));
        exp_st(32'h20, 32'h10C);
        exp_st(32'h24, 32'h0);
        rst_off();
        wait_ret(7);
        for (int i = 0; i < 7; i++) check($sformatf("retire pc %0d", i), rpc[i], bpc[i]);
        check("bne not-taken cycles", 32'(rcyc[1] - rcyc[0]), 32'd3);
        check("jal cycles", 32'(rcyc[2] - rcyc[1]), 32'd4);
        check("beq taken cycles", 32'(rcyc[3] - rcyc[2]), 32'd3);
        check("branch scoreboard drained", 32'(sb_a.size()), 32'd0);

        // x0 hardwired; reset during a stalled store
        rst_on();
        wait_n = 0;
        put(addi(5'd0, 5'd0, 12'd7));
        put(r_t(7'h00, 5'd0, 5'd0, 3'b000, 5'd6));
        put(sw_t(5'd6, 12'h30));
        put(addi(5'd9, 5'd0, 12'd77));
        put(sw_t(5'd9, 12'h34));
        exp_st(32'h30, 32'h0);
        rst_off();
        wait_ret(3);
        wait_n = 3;
        begin
            int k = 0;
            while (!(mem_req && mem_we && !mem_ready) && k < 200) begin
                @(negedge clk);
                k++;
            end
            check("store wait reached", 32'(mem_req && mem_we && !mem_ready), 32'd1);
        end
        s0 = n_st;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("req dropped in reset", 32'(mem_req), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("no store landed", 32'(n_st - s0), 32'd0);
        @(negedge clk);
        check("pc after mid reset", pc_dbg, 32'h100);
        check("x0 scoreboard drained", 32'(sb_a.size()), 32'd0);

        // Illegal instruction word
        rst_on();
        wait_n = 0;
        put(32'hFFFF_FFFF);
        put(addi(5'd1, 5'd0, 12'd3));
        put(sw_t(5'd1, 12'h40));
`ifdef RISCV_ILLEGAL_TRAP_EN
        rst_off();
        repeat (6) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("halt no req", 32'(mem_req), 32'd0);
            @(negedge clk);
        end
        check("trap set", 32'(trap), 32'd1);
        check("halt no retire", 32'(rpc.size()), 32'd0);
        check("halt pc frozen", pc_dbg, 32'h100);
`else
        exp_st(32'h40, 32'd3);
        rst_off();
        wait_ret(3);
        check("illegal retires pc", rpc[0], 32'h100);
        check("next pc after illegal", rpc[1], 32'h104);
        check("trap stays 0", 32'(trap), 32'd0);
        check("illegal scoreboard drained", 32'(sb_a.size()), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
